// File: rtl/plot_ctrl_pkg.sv
// Shared types and default geometry for the plot controller.
// State encodings, box/screen defaults and a small helper.
package plot_ctrl_pkg;

    typedef enum logic [2:0] {
        S_LOAD_X        = 3'd0,
        S_LOAD_X_WAIT   = 3'd1,
        S_LOAD_Y_C      = 3'd2,
        S_LOAD_Y_C_WAIT = 3'd3,
        S_DRAW          = 3'd4,
        S_CLEAR         = 3'd5,
        S_DONE          = 3'd6
    } state_t;

    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    localparam int DEF_BOX_W    = 4;
    localparam int DEF_BOX_H    = 4;
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/plot_scan_counter.sv
// 2D raster counter: x runs 0..x_end, then wraps and bumps y.
// Limits are run-time inputs so one counter serves box and screen scans.
module plot_scan_counter #(
    parameter int W_MAX = 4,
    parameter int H_MAX = 4,
    parameter int X_W   = 8,
    parameter int Y_W   = 7
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clr,
    input  logic           en,
    input  logic [X_W-1:0] x_end,
    input  logic [Y_W-1:0] y_end,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    localparam logic [X_W-1:0] X_CAP = X_W'(W_MAX - 1);
    localparam logic [Y_W-1:0] Y_CAP = Y_W'(H_MAX - 1);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [X_W-1:0] w_x_end;
    logic [Y_W-1:0] w_y_end;
    logic           w_x_wrap;

    assign w_x_end  = (x_end > X_CAP) ? X_CAP : x_end;
    assign w_y_end  = (y_end > Y_CAP) ? Y_CAP : y_end;
    assign w_x_wrap = (r_x == w_x_end);

    // Raster step: x increments, wraps at the row end and advances y.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (en) begin
            if (w_x_wrap) begin
                r_x <= '0;
                r_y <= (r_y == w_y_end) ? '0 : r_y + Y_W'(1);
            end else begin
                r_x <= r_x + X_W'(1);
            end
        end
    end

    assign x    = r_x;
    assign y    = r_y;
    assign last = w_x_wrap && (r_y == w_y_end);

endmodule

// File: rtl/plot_controller.sv
// Plot controller: load X, load Y/colour, then draw a BOX_W x BOX_H block.
// Optional full-screen clear compiled in with PLOT_CTRL_CLEAR_EN.
module plot_controller
    import plot_ctrl_pkg::*;
#(
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int BOX_W    = DEF_BOX_W,
    parameter int BOX_H    = DEF_BOX_H,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           go,
`ifdef PLOT_CTRL_CLEAR_EN
    input  logic           clear,
`endif
    output logic           ld_x,
    output logic           ld_y,
    output logic           ld_colour,
    output logic           writeEn,
    output logic [X_W-1:0] x_off,
    output logic [Y_W-1:0] y_off,
    output logic           use_bg,
    output logic           busy,
    output logic           done
);

    state_t         r_state;
    state_t         w_next;
    logic           w_scan;
    logic           w_last;
    logic [X_W-1:0] w_x;
    logic [Y_W-1:0] w_y;
    logic [X_W-1:0] w_x_end;
    logic [Y_W-1:0] w_y_end;

    assign w_scan = (r_state == S_DRAW) || (r_state == S_CLEAR);

`ifdef PLOT_CTRL_CLEAR_EN
    assign w_x_end = (r_state == S_CLEAR) ? X_W'(SCREEN_W - 1) : X_W'(BOX_W - 1);
    assign w_y_end = (r_state == S_CLEAR) ? Y_W'(SCREEN_H - 1) : Y_W'(BOX_H - 1);
`else
    assign w_x_end = X_W'(BOX_W - 1);
    assign w_y_end = Y_W'(BOX_H - 1);
`endif

    plot_scan_counter #(
        .W_MAX (imax(BOX_W, SCREEN_W)),
        .H_MAX (imax(BOX_H, SCREEN_H)),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .clr   (!w_scan),
        .en    (w_scan),
        .x_end (w_x_end),
        .y_end (w_y_end),
        .x     (w_x),
        .y     (w_y),
        .last  (w_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_LOAD_X;
        else       r_state <= w_next;
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        w_next    = r_state;
        ld_x      = 1'b0;
        ld_y      = 1'b0;
        ld_colour = 1'b0;
        writeEn   = w_scan;
        busy      = w_scan;
        done      = 1'b0;
        use_bg    = 1'b0;
        x_off     = w_x;
        y_off     = w_y;
        case (r_state)
            S_LOAD_X: begin
                ld_x = 1'b1;
                if (load) w_next = S_LOAD_X_WAIT;
`ifdef PLOT_CTRL_CLEAR_EN
                else if (clear) w_next = S_CLEAR;
`endif
            end
            S_LOAD_X_WAIT: begin
                ld_x = 1'b1;
                if (!load) w_next = S_LOAD_Y_C;
            end
            S_LOAD_Y_C: begin
                ld_y      = 1'b1;
                ld_colour = 1'b1;
                if (go) w_next = S_LOAD_Y_C_WAIT;
            end
            S_LOAD_Y_C_WAIT: begin
                ld_y      = 1'b1;
                ld_colour = 1'b1;
                if (!go) w_next = S_DRAW;
            end
            S_DRAW: begin
                if (w_last) w_next = S_DONE;
            end
`ifdef PLOT_CTRL_CLEAR_EN
            S_CLEAR: begin
                use_bg = 1'b1;
                if (w_last) w_next = S_DONE;
            end
`endif
            S_DONE: begin
                done = 1'b1;
                if (load) w_next = S_LOAD_X;
            end
            default: w_next = S_LOAD_X;
        endcase
    end

endmodule

// File: tb/tb_plot_controller.sv
// Testbench for plot_controller (default 4x4 and a 3x2 instance).
// Clear-mode tests compile in with PLOT_CTRL_CLEAR_EN.
module tb_plot_controller;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
    } pix_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic       go;
`ifdef PLOT_CTRL_CLEAR_EN
    logic       clear;
`endif

    logic       ld_x, ld_y, ld_colour, writeEn, use_bg, busy, done;
    logic [7:0] x_off;
    logic [6:0] y_off;

    logic       ld_x2, ld_y2, ld_colour2, wr2, use_bg2, busy2, done2;
    logic [7:0] x2;
    logic [6:0] y2;

    int   n_tests = 0;
    int   n_fail  = 0;
    pix_t q[$];

    always #5 clk = ~clk;

    plot_controller dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .go        (go),
`ifdef PLOT_CTRL_CLEAR_EN
        .clear     (clear),
`endif
        .ld_x      (ld_x),
        .ld_y      (ld_y),
        .ld_colour (ld_colour),
        .writeEn   (writeEn),
        .x_off     (x_off),
        .y_off     (y_off),
        .use_bg    (use_bg),
        .busy      (busy),
        .done      (done)
    );

    plot_controller #(.BOX_W(3), .BOX_H(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .go        (go),
`ifdef PLOT_CTRL_CLEAR_EN
        .clear     (clear),
`endif
        .ld_x      (ld_x2),
        .ld_y      (ld_y2),
        .ld_colour (ld_colour2),
        .writeEn   (wr2),
        .x_off     (x2),
        .y_off     (y2),
        .use_bg    (use_bg2),
        .busy      (busy2),
        .done      (done2)
    );

    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        go    = 1'b0;
`ifdef PLOT_CTRL_CLEAR_EN
        clear = 1'b0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Load press/release then go press/release; returns on the
    // negedge where go is released (next negedge is the first write).
    task automatic do_load_go();
        load = 1'b1;
        repeat (2) @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        go = 1'b1;
        repeat (2) @(negedge clk);
        go = 1'b0;
    endtask

    task automatic push_box(input int w, input int h);
        pix_t p;
        q.delete();
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++) begin
                p.x = 8'(xx);
                p.y = 7'(yy);
                q.push_back(p);
            end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load  = 1'b0;
        go    = 1'b0;
`ifdef PLOT_CTRL_CLEAR_EN
        clear = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_tests++;
        if ({ld_x, ld_y, ld_colour, writeEn, use_bg, busy, done} !== 7'b1000000
            || x_off !== 8'd0 || y_off !== 7'd0) begin
            n_fail++;
            $display("FAIL reset: outs=%b x=%0d y=%0d, want 1000000 x=0 y=0",
                     {ld_x, ld_y, ld_colour, writeEn, use_bg, busy, done}, x_off, y_off);
        end
        reset = 1'b0;
    endtask

    task automatic test_draw();
        pix_t e;
        load = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_tests++;
            if (ld_x !== 1'b1 || ld_y !== 1'b0 || writeEn !== 1'b0) begin
                n_fail++;
                $display("FAIL load_x_wait: ld_x=%b ld_y=%b wr=%b, want 1 0 0",
                         ld_x, ld_y, writeEn);
            end
        end
        load = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ld_x !== 1'b0 || ld_y !== 1'b1 || ld_colour !== 1'b1) begin
            n_fail++;
            $display("FAIL load_y_c: ld_x=%b ld_y=%b ld_c=%b, want 0 1 1",
                     ld_x, ld_y, ld_colour);
        end
        go = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (ld_y !== 1'b1 || ld_colour !== 1'b1 || writeEn !== 1'b0) begin
                n_fail++;
                $display("FAIL load_y_c_wait: ld_y=%b ld_c=%b wr=%b, want 1 1 0",
                         ld_y, ld_colour, writeEn);
            end
        end
        go = 1'b0;
        push_box(4, 4);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            e = q.pop_front();
            n_tests++;
            if (writeEn !== 1'b1 || busy !== 1'b1 || x_off !== e.x || y_off !== e.y) begin
                n_fail++;
                $display("FAIL draw[%0d]: wr=%b busy=%b (%0d,%0d), want 1 1 (%0d,%0d)",
                         i, writeEn, busy, x_off, y_off, e.x, e.y);
            end
        end
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (done !== 1'b1 || writeEn !== 1'b0 || busy !== 1'b0
                || x_off !== 8'd0 || y_off !== 7'd0) begin
                n_fail++;
                $display("FAIL draw_done: done=%b wr=%b busy=%b (%0d,%0d), want 1 0 0 (0,0)",
                         done, writeEn, busy, x_off, y_off);
            end
        end
    endtask

    task automatic test_small_box();
        pix_t e;
        do_reset();
        do_load_go();
        push_box(3, 2);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e = q.pop_front();
            n_tests++;
            if (wr2 !== 1'b1 || x2 !== e.x || y2 !== e.y) begin
                n_fail++;
                $display("FAIL box3x2[%0d]: wr=%b (%0d,%0d), want 1 (%0d,%0d)",
                         i, wr2, x2, y2, e.x, e.y);
            end
        end
        @(negedge clk);
        n_tests++;
        if (done2 !== 1'b1 || wr2 !== 1'b0) begin
            n_fail++;
            $display("FAIL box3x2_done: done=%b wr=%b, want 1 0", done2, wr2);
        end
    endtask

    task automatic test_reset_mid_draw();
        logic seen_done;
        do_reset();
        do_load_go();
        repeat (7) @(negedge clk);
        n_tests++;
        if (writeEn !== 1'b1 || x_off !== 8'd2 || y_off !== 7'd1) begin
            n_fail++;
            $display("FAIL mid_draw_7th: wr=%b (%0d,%0d), want 1 (2,1)",
                     writeEn, x_off, y_off);
        end
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (writeEn !== 1'b0 || ld_x !== 1'b1 || done !== 1'b0 || busy !== 1'b0
            || x_off !== 8'd0 || y_off !== 7'd0) begin
            n_fail++;
            $display("FAIL mid_reset: wr=%b ld_x=%b done=%b busy=%b (%0d,%0d), want 0 1 0 0 (0,0)",
                     writeEn, ld_x, done, busy, x_off, y_off);
        end
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen_done = seen_done | done | writeEn;
        end
        n_tests++;
        if (seen_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_idle: done/write seen=%b, want 0", seen_done);
        end
    endtask

    task automatic test_load_ignored();
        pix_t e;
        do_reset();
        do_load_go();
        push_box(4, 4);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            e = q.pop_front();
            n_tests++;
            if (writeEn !== 1'b1 || x_off !== e.x || y_off !== e.y) begin
                n_fail++;
                $display("FAIL load_ign[%0d]: wr=%b (%0d,%0d), want 1 (%0d,%0d)",
                         i, writeEn, x_off, y_off, e.x, e.y);
            end
            if (i == 3) load = 1'b1;
            if (i == 5) load = 1'b0;
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || writeEn !== 1'b0) begin
            n_fail++;
            $display("FAIL load_ign_done: done=%b wr=%b, want 1 0", done, writeEn);
        end
        load = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ld_x !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_to_load_x: ld_x=%b done=%b, want 1 0", ld_x, done);
        end
        load = 1'b0;
    endtask

`ifdef PLOT_CTRL_CLEAR_EN
    task automatic test_clear();
        pix_t e;
        do_reset();
        clear = 1'b1;
        push_box(160, 120);
        for (int i = 0; i < 19200; i++) begin
            @(negedge clk);
            if (i == 0) clear = 1'b0;
            e = q.pop_front();
            n_tests++;
            if (writeEn !== 1'b1 || use_bg !== 1'b1 || busy !== 1'b1
                || x_off !== e.x || y_off !== e.y) begin
                n_fail++;
                $display("FAIL clear[%0d]: wr=%b bg=%b busy=%b (%0d,%0d), want 1 1 1 (%0d,%0d)",
                         i, writeEn, use_bg, busy, x_off, y_off, e.x, e.y);
            end
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || writeEn !== 1'b0 || use_bg !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_done: done=%b wr=%b bg=%b, want 1 0 0",
                     done, writeEn, use_bg);
        end
    endtask

    task automatic test_clear_and_load();
        do_reset();
        clear = 1'b1;
        load  = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ld_x !== 1'b1 || busy !== 1'b0 || use_bg !== 1'b0 || writeEn !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_load_prio: ld_x=%b busy=%b bg=%b wr=%b, want 1 0 0 0",
                     ld_x, busy, use_bg, writeEn);
        end
        clear = 1'b0;
        load  = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ld_y !== 1'b1 || ld_x !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_load_next: ld_y=%b ld_x=%b, want 1 0", ld_y, ld_x);
        end
    endtask
`endif

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_draw();
        test_small_box();
        test_reset_mid_draw();
        test_load_ignored();
`ifdef PLOT_CTRL_CLEAR_EN
        test_clear();
        test_clear_and_load();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
